shift_seq: RTL and testbench

- Multi-cycle iterative shift unit for area-constrained Goldcrest configurations.
- Replaces the single-cycle 32-bit barrel shifter with a STEP-bit-per-cycle shift stage plus a sequencing FSM.
- Sits in EX and is handed SLL/SRL/SRA operations by the ALU issue logic through a valid/ready handshake.
- The result returns through a second valid/ready handshake. One operation is in flight at a time.

---
 rtl/shift_seq_pkg.sv | 22 ++
 rtl/shift_seq_shift_step.sv | 26 ++
 rtl/shift_seq.sv | 113 +++++++++++
 tb/tb_shift_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the iterative shift unit (shift_seq).
package shift_seq_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int SHAMT_W      = 5;

  // Shift operation encoding as presented by the ALU issue logic.
  typedef enum logic [1:0] {
    SLL     = 2'b00,
    SRL     = 2'b01,
    SRL_ALT = 2'b10,
    SRA     = 2'b11
  } shift_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_shift_step.sv
// One iteration of the shift datapath: moves acc by k bit positions.
// SLL/SRL fill with zero, SRA replicates the accumulator's sign bit.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int KW   = 3
) (
  input  logic [XLEN-1:0] acc_i,
  input  logic [KW-1:0]   k_i,
  input  shift_op_e       op_i,
  output logic [XLEN-1:0] acc_o
);

  // Select the shift flavour; SRL_ALT falls into the logical-right default.
  always_comb begin
    // NOTE: assign a default first so every path drives acc_o and no latch is inferred.
    acc_o = acc_i >> k_i;
    case (op_i)
      SLL:     acc_o = acc_i << k_i;
      SRA:     acc_o = XLEN'($signed(acc_i) >>> k_i);
      default: acc_o = acc_i >> k_i;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift unit: shifts at most STEP bits per cycle under a
// three-state sequencer, with valid/ready handshakes on both sides.
// Optional macro SHIFT_SEQ_FLUSH_EN adds a flush input that abandons the
// operation in flight and returns to IDLE on the next edge.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int STEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SHIFT_SEQ_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [XLEN-1:0]    in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic               busy
);

  localparam int KW = $clog2(STEP) + 1;
  // Shift amounts wrap modulo XLEN, so only the low log2(XLEN) bits survive.
  localparam logic [SHAMT_W-1:0] SHAMT_MASK = SHAMT_W'(XLEN - 1);

  state_e               state_q;
  shift_op_e            op_q;
  logic [XLEN-1:0]      acc_q;
  logic [SHAMT_W-1:0]   remaining_q;
  logic                 out_valid_q;
  logic [XLEN-1:0]      out_result_q;

  logic                 flush_w;
  logic [SHAMT_W-1:0]   shamt_w;
  logic [KW-1:0]        step_k;
  logic [SHAMT_W-1:0]   remaining_d;
  logic [XLEN-1:0]      acc_d;

`ifdef SHIFT_SEQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign shamt_w     = in_shamt & SHAMT_MASK;
  // k = min(remaining, STEP); k never reaches STEP when STEP exceeds any legal remaining.
  assign step_k      = (int'(remaining_q) < STEP) ? KW'(remaining_q) : KW'(STEP);
  assign remaining_d = remaining_q - SHAMT_W'(step_k);

  shift_step #(
    .XLEN (XLEN),
    .KW   (KW)
  ) u_shift_step (
    .acc_i (acc_q),
    .k_i   (step_k),
    .op_i  (op_q),
    .acc_o (acc_d)
  );

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

  // Sequencer and datapath registers; flush overrides accept and handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= SLL;
      acc_q        <= '0;
      remaining_q  <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else if (flush_w) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc_q       <= in_a;
            op_q        <= shift_op_e'(in_op);
            remaining_q <= shamt_w;
            state_q     <= (shamt_w != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          acc_q       <= acc_d;
          remaining_q <= remaining_d;
          if (remaining_d == '0) state_q <= DONE;
        end
        DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            out_valid_q  <= 1'b1;
            out_result_q <= acc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Directed self-checking bench for shift_seq (XLEN=32, STEP=4).
module tb_shift_seq;
  import shift_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = '0;
  logic [4:0]  in_shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        busy;
`ifdef SHIFT_SEQ_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  shift_seq #(.XLEN(32), .STEP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SHIFT_SEQ_FLUSH_EN
    .flush      (flush),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one op and let the accept edge happen; scrambles inputs afterwards.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    in_valid = 1'b1; in_op = op; in_a = a; in_shamt = sh;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = ~op; in_a = ~a; in_shamt = ~sh;
  endtask

  // Count cycles from the accept edge until out_valid; track in_ready staying low.
  task automatic wait_done(output int lat, output logic rdy_low);
    lat = 1; rdy_low = 1'b1;
    if (in_ready !== 1'b0) rdy_low = 1'b0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0) rdy_low = 1'b0;
      lat++;
    end
    lat--;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                       output int lat, output logic rdy_low);
    start_op(op, a, sh);
    wait_done(lat, rdy_low);
  endtask

  // Hand off the result while offering a new op the unit must not take.
  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'hAAAA_AAAA; in_shamt = 5'd0;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", out_valid); tests_failed++; end
    tests_run++;
    if (out_result !== 32'h0) begin $display("FAIL reset_out_result: got %h want 0", out_result); tests_failed++; end
    tests_run++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); tests_failed++; end
    tests_run++;
    if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b want 1", in_ready); tests_failed++; end
    tests_run++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sll_long();
    int lat; logic rdy_low;
    do_op(2'b00, 32'h0000_0001, 5'd31, lat, rdy_low);
    if (out_result !== 32'h8000_0000) begin $display("FAIL sll31_result: got %h want 80000000", out_result); tests_failed++; end
    tests_run++;
    if (lat != 9) begin $display("FAIL sll31_latency: got %0d want 9", lat); tests_failed++; end
    tests_run++;
    if (rdy_low !== 1'b1) begin $display("FAIL sll31_in_ready_low: in_ready rose during op"); tests_failed++; end
    tests_run++;
    drain();
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL sll31_handoff: in_ready=%b busy=%b out_valid=%b want 1 0 0", in_ready, busy, out_valid);
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_right_shifts();
    int lat; logic rdy_low;
    logic [1:0]  ops  [6] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10};
    logic [31:0] as   [6] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 32'hF000_0000};
    logic [4:0]  shs  [6] = '{5'd4, 5'd4, 5'd1, 5'd5, 5'd8, 5'd0};
    logic [31:0] exps [6] = '{32'hF800_0000, 32'h0800_0000, 32'hC000_0000, 32'hFC00_0000, 32'h0080_0000, 32'hF000_0000};
    int          lats [6] = '{2, 2, 2, 3, 3, 1};
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], as[i], shs[i], lat, rdy_low);
      if (out_result !== exps[i] || lat != lats[i]) begin
        $display("FAIL right_shift[%0d]: result %h lat %0d want %h lat %0d", i, out_result, lat, exps[i], lats[i]);
        tests_failed++;
      end
      tests_run++;
      drain();
    end
  endtask

  task automatic test_zero_shamt();
    int lat; logic rdy_low;
    do_op(2'b11, 32'hDEAD_BEEF, 5'd0, lat, rdy_low);
    if (out_result !== 32'hDEAD_BEEF) begin $display("FAIL zero_shamt_result: got %h want deadbeef", out_result); tests_failed++; end
    tests_run++;
    if (lat != 1) begin $display("FAIL zero_shamt_latency: got %0d want 1", lat); tests_failed++; end
    tests_run++;
    drain();
  endtask

  task automatic test_backpressure();
    int lat; logic rdy_low; logic stable;
    do_op(2'b00, 32'h1234_5678, 5'd8, lat, rdy_low);
    if (out_result !== 32'h3456_7800 || lat != 3) begin
      $display("FAIL bp_result: result %h lat %0d want 34567800 lat 3", out_result, lat);
      tests_failed++;
    end
    tests_run++;
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i % 2 == 0); in_a = 32'h0F0F_0000 + 32'(i); in_shamt = 5'(i);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_result !== 32'h3456_7800 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    if (stable !== 1'b1) begin $display("FAIL bp_hold: result %h valid %b not held", out_result, out_valid); tests_failed++; end
    tests_run++;
    drain();
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_reset_mid_op();
    int lat; logic rdy_low;
    start_op(2'b00, 32'h0000_0001, 5'd20);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL rst_mid_shift: out_valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
      tests_failed++;
    end
    tests_run++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(2'b01, 32'hFFFF_0000, 5'd16, lat, rdy_low);
    if (out_result !== 32'h0000_FFFF || lat != 5) begin
      $display("FAIL rst_recover: result %h lat %0d want 0000ffff lat 5", out_result, lat);
      tests_failed++;
    end
    tests_run++;
    #2 rst_n = 1'b0;
    #1;
    if (out_valid !== 1'b0 || out_result !== 32'h0) begin
      $display("FAIL rst_in_done: out_valid=%b result %h want 0 00000000", out_valid, out_result);
      tests_failed++;
    end
    tests_run++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef SHIFT_SEQ_FLUSH_EN
  task automatic test_flush();
    int lat; logic rdy_low; logic quiet;
    start_op(2'b00, 32'h0000_0001, 5'd20);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    quiet = (busy === 1'b0) && (in_ready === 1'b1) && (out_valid === 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    if (quiet !== 1'b1) begin $display("FAIL flush_shift: busy=%b out_valid=%b", busy, out_valid); tests_failed++; end
    tests_run++;
    do_op(2'b11, 32'h1111_2222, 5'd0, lat, rdy_low);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL flush_done: out_valid=%b busy=%b want 0 0", out_valid, busy);
      tests_failed++;
    end
    tests_run++;
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'h5; in_shamt = 5'd3; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL flush_blocks_accept: busy=%b in_ready=%b want 0 1", busy, in_ready);
      tests_failed++;
    end
    tests_run++;
  endtask
`endif

  initial begin
    test_reset();
    test_sll_long();
    test_right_shifts();
    test_zero_shamt();
    test_backpressure();
    test_reset_mid_op();
`ifdef SHIFT_SEQ_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
